// File: rtl/mmm_seq_ctrl.sv
// ============================================================================
//  Module   : mmm_seq_ctrl
//  Brief    : Sequencer for one Montgomery modular multiplication pass:
//             clear, WIDTH iterations, conditional subtract, result load.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmm_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             ge_i,
   output logic             rst_mmm_o,
   output logic             iter_o,
   output logic [CNT_W-1:0] bit_idx_o,
   output logic             sub_o,
   output logic             ld_r_o,
   output logic             lock_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLEAR = 3'd1,
      S_ITER  = 3'd2,
      S_SUB   = 3'd3,
      S_LOAD  = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [CNT_W-1:0] w_bit_cnt_nxt;
   logic             r_ge_q;
   logic             w_ge_q_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_ge_q    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_ge_q    <= w_ge_q_nxt;
      end
   end

   // Abort bypasses the enable so a stalled pass can still be cancelled.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_ge_q_nxt    = r_ge_q;
      if (abort_i && (r_state != S_IDLE)) begin
         w_state_nxt   = S_IDLE;
         w_bit_cnt_nxt = '0;
         w_ge_q_nxt    = 1'b0;
      end else if (en) begin
         case (r_state)
            S_IDLE: begin
               if (start_i) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
               w_bit_cnt_nxt = '0;
               w_ge_q_nxt    = 1'b0;
               w_state_nxt   = S_ITER;
            end
            S_ITER: begin
               if (r_bit_cnt == C_LAST_BIT) begin
                  w_state_nxt = S_SUB;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               end
            end
            S_SUB: begin
               w_ge_q_nxt  = ge_i;
               w_state_nxt = S_LOAD;
            end
            S_LOAD:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   // Moore decode: outputs depend on registered state only.
   always_comb begin
      rst_mmm_o = 1'b1;
      iter_o    = 1'b0;
      bit_idx_o = '0;
      sub_o     = 1'b0;
      ld_r_o    = 1'b0;
      lock_o    = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      case (r_state)
         S_CLEAR: begin
            rst_mmm_o = 1'b0;
            busy_o    = 1'b1;
         end
         S_ITER: begin
            iter_o    = 1'b1;
            bit_idx_o = r_bit_cnt;
            busy_o    = 1'b1;
         end
         S_SUB: begin
            sub_o  = 1'b1;
            busy_o = 1'b1;
         end
         S_LOAD: begin
            ld_r_o = 1'b1;
            lock_o = r_ge_q;
            busy_o = 1'b1;
         end
         S_DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_mmm_seq_ctrl.sv
// ============================================================================
//  Module   : tb_mmm_seq_ctrl
//  Brief    : Self-checking bench for mmm_seq_ctrl using an expected-output queue.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mmm_seq_ctrl;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b1;
   logic       start_i = 1'b0;
   logic       abort_i = 1'b0;
   logic       ge_i = 1'b0;
   logic       rst_mmm_o, iter_o, sub_o, ld_r_o, lock_o, busy_o, done_o;
   logic [1:0] bit_idx_o;
   logic [8:0] obs;
   logic [8:0] exp_v;
   logic [8:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   mmm_seq_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .start_i   (start_i),
      .abort_i   (abort_i),
      .ge_i      (ge_i),
      .rst_mmm_o (rst_mmm_o),
      .iter_o    (iter_o),
      .bit_idx_o (bit_idx_o),
      .sub_o     (sub_o),
      .ld_r_o    (ld_r_o),
      .lock_o    (lock_o),
      .busy_o    (busy_o),
      .done_o    (done_o)
   );

   always #5 clk = ~clk;

   // {rst_mmm, iter, bit_idx[1:0], sub, ld_r, lock, busy, done}
   assign obs = {rst_mmm_o, iter_o, bit_idx_o, sub_o, ld_r_o, lock_o, busy_o, done_o};

   // Expected outputs per phase: 0 idle, 1 clear, 2 iter, 3 sub, 4 load, 5 done
   function automatic logic [8:0] ev(input int ph, input int idx, input logic lk);
      case (ph)
         1:       return 9'b0_0_00_0_0_0_1_0;
         2:       return {1'b1, 1'b1, 2'(idx), 5'b0_0_0_1_0};
         3:       return 9'b1_0_00_1_0_0_1_0;
         4:       return {6'b1_0_00_0_1, lk, 2'b1_0};
         5:       return 9'b1_0_00_0_0_0_0_1;
         default: return 9'b1_0_00_0_0_0_0_0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pass(input logic lk);
      exp_q.push_back(ev(1, 0, 1'b0));
      for (int i = 0; i < W; i++) exp_q.push_back(ev(2, i, 1'b0));
      exp_q.push_back(ev(3, 0, 1'b0));
      exp_q.push_back(ev(4, 0, lk));
      exp_q.push_back(ev(5, 0, 1'b0));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #2;
      checks++;
      if (obs !== ev(0, 0, 1'b0)) begin
         errors++;
         $display("FAIL reset_hold: got %b expected %b", obs, ev(0, 0, 1'b0));
      end
      step();
      rst = 1'b0;
      step();
      step();
      checks++;
      if (obs !== ev(0, 0, 1'b0)) begin
         errors++;
         $display("FAIL reset_release: got %b expected %b", obs, ev(0, 0, 1'b0));
      end
   endtask

   task automatic test_pass(input logic ge);
      int k;
      ge_i    = ge;
      start_i = 1'b1;
      push_pass(ge);
      exp_q.push_back(ev(0, 0, 1'b0));
      step();
      start_i = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL pass_ge%0b[cycle %0d]: got %b expected %b", ge, k + 1, obs, exp_v);
         end
         k++;
         step();
      end
   endtask

   task automatic test_en_toggle();
      logic [8:0] seq[$];
      int k;
      ge_i    = 1'b1;
      start_i = 1'b1;
      en      = 1'b1;
      push_pass(1'b1);
      while (exp_q.size() > 0) seq.push_back(exp_q.pop_front());
      foreach (seq[i]) begin
         exp_q.push_back(seq[i]);
         exp_q.push_back(seq[i]);
      end
      exp_q.push_back(ev(0, 0, 1'b0));
      step();
      start_i = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL en_toggle[%0d]: got %b expected %b", k, obs, exp_v);
         end
         en = (k % 2 == 1);
         k++;
         step();
      end
      en = 1'b1;
   endtask

   task automatic test_abort();
      int k;
      ge_i    = 1'b1;
      start_i = 1'b1;
      abort_i = 1'b1;
      exp_q.push_back(ev(1, 0, 1'b0));
      for (int i = 0; i < 3; i++) exp_q.push_back(ev(2, i, 1'b0));
      for (int i = 0; i < 4; i++) exp_q.push_back(ev(0, 0, 1'b0));
      step();
      start_i = 1'b0;
      abort_i = 1'b0;
      k = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL abort[%0d]: got %b expected %b", k, obs, exp_v);
         end
         abort_i = (k == 3);
         k++;
         step();
      end
      abort_i = 1'b0;
   endtask

   task automatic test_back_to_back();
      int k;
      int n;
      ge_i    = 1'b0;
      start_i = 1'b1;
      for (int p = 0; p < 2; p++) begin
         push_pass(1'b0);
         exp_q.push_back(ev(0, 0, 1'b0));
      end
      n = exp_q.size();
      step();
      k = 0;
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got %b expected %b", k, obs, exp_v);
         end
         if (k == n - 1) start_i = 1'b0;
         k++;
         step();
      end
      start_i = 1'b0;
   endtask

   task automatic test_async_reset();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      step();
      step();
      checks++;
      if (obs !== ev(2, 1, 1'b0)) begin
         errors++;
         $display("FAIL async_rst_pre: got %b expected %b", obs, ev(2, 1, 1'b0));
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if (obs !== ev(0, 0, 1'b0)) begin
         errors++;
         $display("FAIL async_rst_now: got %b expected %b", obs, ev(0, 0, 1'b0));
      end
      #1;
      rst = 1'b0;
      step();
      checks++;
      if (obs !== ev(0, 0, 1'b0)) begin
         errors++;
         $display("FAIL async_rst_after: got %b expected %b", obs, ev(0, 0, 1'b0));
      end
   endtask

   initial begin
      test_reset();
      test_pass(1'b1);
      test_pass(1'b0);
      test_en_toggle();
      test_abort();
      test_pass(1'b1);
      test_back_to_back();
      test_async_reset();
      test_pass(1'b0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
